// File: rtl/prog_univ_counter.sv
// Bounded up/down counter with programmable limits, step and boundary mode
// (wrap, saturate, bounce, one-shot), plus registered event and done flags.
module prog_univ_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [1:0]   mode,
    input  logic [W-1:0] step,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         dir,
    output logic         evt,
    output logic         done,
    output logic         max_tick,
    output logic         min_tick,
    output logic         cfg_err
);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    // Carry out of the top bit is kept, so overflow past 2^W-1 still counts as an event
    function automatic logic up_event(input logic [W-1:0] cur, input logic [W-1:0] inc,
                                      input logic [W-1:0] lim);
        logic [W:0] sum;
        sum      = {1'b0, cur} + {1'b0, inc};
        up_event = (sum > {1'b0, lim});
    endfunction

    function automatic logic down_event(input logic [W-1:0] cur, input logic [W-1:0] dec,
                                        input logic [W-1:0] lim);
        logic [W:0] thr;
        thr        = {1'b0, lim} + {1'b0, dec};
        down_event = ({1'b0, cur} < thr);
    endfunction

    logic [W-1:0] q_r;
    logic         dir_r;
    logic         evt_r;
    logic         done_r;
    logic [W-1:0] q_nxt_s;
    logic         dir_nxt_s;
    logic         evt_nxt_s;
    logic         done_nxt_s;
    logic         cfg_err_s;
    logic         count_ok_s;
    logic         eff_up_s;

    assign cfg_err_s  = (lo > hi);
    assign count_ok_s = en && !cfg_err_s && (step != {W{1'b0}})
                        && !((mode == MODE_ONESHOT) && done_r);
    // In bounce the ping-pong state, not the up input, picks the direction
    assign eff_up_s   = (mode == MODE_BOUNCE) ? dir_r : up;

    // Next-state selection: clear, load, count step or hold
    always_comb begin
        q_nxt_s    = q_r;
        dir_nxt_s  = dir_r;
        evt_nxt_s  = 1'b0;
        done_nxt_s = done_r;
        if (clr) begin
            q_nxt_s    = lo;
            dir_nxt_s  = up;
            done_nxt_s = 1'b0;
        end else if (load) begin
            q_nxt_s    = d;
            dir_nxt_s  = up;
            done_nxt_s = 1'b0;
        end else begin
            if (mode != MODE_ONESHOT) begin
                done_nxt_s = 1'b0;
            end else begin
                done_nxt_s = done_r;
            end
            if (count_ok_s) begin
                if (mode == MODE_BOUNCE) begin
                    dir_nxt_s = dir_r;
                end else begin
                    dir_nxt_s = up;
                end
                if (eff_up_s) begin
                    if (up_event(q_r, step, hi)) begin
                        evt_nxt_s = 1'b1;
                        case (mode)
                            MODE_WRAP:    q_nxt_s = lo;
                            MODE_SAT:     q_nxt_s = hi;
                            MODE_BOUNCE: begin
                                q_nxt_s   = hi;
                                dir_nxt_s = 1'b0;
                            end
                            MODE_ONESHOT: begin
                                q_nxt_s    = hi;
                                done_nxt_s = 1'b1;
                            end
                            default:      q_nxt_s = hi;
                        endcase
                    end else begin
                        q_nxt_s = q_r + step;
                    end
                end else begin
                    if (down_event(q_r, step, lo)) begin
                        evt_nxt_s = 1'b1;
                        case (mode)
                            MODE_WRAP:    q_nxt_s = hi;
                            MODE_SAT:     q_nxt_s = lo;
                            MODE_BOUNCE: begin
                                q_nxt_s   = lo;
                                dir_nxt_s = 1'b1;
                            end
                            MODE_ONESHOT: begin
                                q_nxt_s    = lo;
                                done_nxt_s = 1'b1;
                            end
                            default:      q_nxt_s = lo;
                        endcase
                    end else begin
                        q_nxt_s = q_r - step;
                    end
                end
            end else begin
                q_nxt_s = q_r;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= {W{1'b0}};
            dir_r  <= 1'b1;
            evt_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt_s;
            dir_r  <= dir_nxt_s;
            evt_r  <= evt_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign q        = q_r;
    assign dir      = dir_r;
    assign evt      = evt_r;
    assign done     = done_r;
    assign max_tick = (q_r == hi);
    assign min_tick = (q_r == lo);
    assign cfg_err  = cfg_err_s;

endmodule

// File: tb/tb_prog_univ_counter.sv
// Table-driven scoreboard bench for prog_univ_counter (W=8).
module tb_prog_univ_counter;

    typedef struct {
        logic       clr, load, en, up;
        logic [1:0] mode;
        logic [7:0] step, lo, hi, d;
        logic [7:0] q;
        logic       dir, evt, done, mx, mn, ce;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] step = 8'd0, lo = 8'd10, hi = 8'd20, d = 8'd0;
    logic [7:0] q;
    logic       dir, evt, done, max_tick, min_tick, cfg_err;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[$];
    vec_t sb[$];

    prog_univ_counter #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .en(en), .up(up),
        .mode(mode), .step(step), .lo(lo), .hi(hi), .d(d),
        .q(q), .dir(dir), .evt(evt), .done(done),
        .max_tick(max_tick), .min_tick(min_tick), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic c, l, e, u, input logic [1:0] m,
                                input logic [7:0] st, lw, hg, dv, eq,
                                input logic edir, eevt, edone, emx, emn, ece);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.up = u; v.mode = m;
        v.step = st; v.lo = lw; v.hi = hg; v.d = dv; v.q = eq;
        v.dir = edir; v.evt = eevt; v.done = edone; v.mx = emx; v.mn = emn; v.ce = ece;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        clr = v.clr; load = v.load; en = v.en; up = v.up; mode = v.mode;
        step = v.step; lo = v.lo; hi = v.hi; d = v.d;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        drive(v);
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d.q", idx), {24'd0, q}, {24'd0, e.q});
        chk($sformatf("v%0d.dir", idx), {31'd0, dir}, {31'd0, e.dir});
        chk($sformatf("v%0d.evt", idx), {31'd0, evt}, {31'd0, e.evt});
        chk($sformatf("v%0d.done", idx), {31'd0, done}, {31'd0, e.done});
        chk($sformatf("v%0d.max_tick", idx), {31'd0, max_tick}, {31'd0, e.mx});
        chk($sformatf("v%0d.min_tick", idx), {31'd0, min_tick}, {31'd0, e.mn});
        chk($sformatf("v%0d.cfg_err", idx), {31'd0, cfg_err}, {31'd0, e.ce});
    endtask

    initial begin
        // clr load en up mode step lo hi d | q dir evt done max min cfg
        // wrap up 10..20 step 3 from 18
        tbl.push_back(mk(0,1,0,1,2'd0,8'd3,8'd10,8'd20,8'd18, 8'd18,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd0,8'd3,8'd10,8'd20,8'd0,  8'd10,1,1,0,0,1,0));
        tbl.push_back(mk(0,0,1,1,2'd0,8'd3,8'd10,8'd20,8'd0,  8'd13,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd0,8'd3,8'd10,8'd20,8'd0,  8'd16,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd0,8'd3,8'd10,8'd20,8'd0,  8'd19,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd0,8'd3,8'd10,8'd20,8'd0,  8'd10,1,1,0,0,1,0));
        // carry past 255 in wrap mode
        tbl.push_back(mk(0,1,0,1,2'd0,8'd10,8'd3,8'd255,8'd250, 8'd250,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd0,8'd10,8'd3,8'd255,8'd0,   8'd3,1,1,0,0,1,0));
        tbl.push_back(mk(0,0,1,1,2'd0,8'd10,8'd3,8'd255,8'd0,   8'd13,1,0,0,0,0,0));
        // saturate down to 5
        tbl.push_back(mk(0,1,0,0,2'd1,8'd4,8'd5,8'd20,8'd12, 8'd12,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,2'd1,8'd4,8'd5,8'd20,8'd0,  8'd8,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,2'd1,8'd4,8'd5,8'd20,8'd0,  8'd5,0,1,0,0,1,0));
        tbl.push_back(mk(0,0,1,0,2'd1,8'd4,8'd5,8'd20,8'd0,  8'd5,0,1,0,0,1,0));
        // bounce 0..7 step 2, up input held low after clr
        tbl.push_back(mk(1,0,0,1,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd0,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,1,0,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd2,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd4,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd6,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd7,0,1,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd5,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd3,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd1,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd0,1,1,0,0,1,0));
        tbl.push_back(mk(0,0,1,0,2'd2,8'd2,8'd0,8'd7,8'd0, 8'd2,1,0,0,0,0,0));
        // one-shot 0..255 step 100
        tbl.push_back(mk(1,0,0,1,2'd3,8'd100,8'd0,8'd255,8'd0, 8'd0,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,1,1,2'd3,8'd100,8'd0,8'd255,8'd0, 8'd100,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd3,8'd100,8'd0,8'd255,8'd0, 8'd200,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd3,8'd100,8'd0,8'd255,8'd0, 8'd255,1,1,1,1,0,0));
        tbl.push_back(mk(0,0,1,1,2'd3,8'd100,8'd0,8'd255,8'd0, 8'd255,1,0,1,1,0,0));
        tbl.push_back(mk(0,1,0,1,2'd3,8'd100,8'd0,8'd255,8'd0, 8'd0,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,1,1,2'd3,8'd100,8'd0,8'd255,8'd0, 8'd100,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd3,8'd100,8'd0,8'd255,8'd0, 8'd200,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd3,8'd100,8'd0,8'd255,8'd0, 8'd255,1,1,1,1,0,0));
        tbl.push_back(mk(0,0,0,1,2'd0,8'd100,8'd0,8'd255,8'd0, 8'd255,1,0,0,1,0,0));
        // priority, bad limits, zero step, entering bounce keeps dir
        tbl.push_back(mk(1,1,0,1,2'd0,8'd1,8'd4,8'd50,8'd30, 8'd4,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,1,1,2'd0,8'd1,8'd9,8'd3,8'd0,   8'd4,1,0,0,0,0,1));
        tbl.push_back(mk(0,1,0,0,2'd0,8'd1,8'd9,8'd3,8'd77,  8'd77,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,0,2'd0,8'd1,8'd9,8'd3,8'd0,   8'd77,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,1,2'd0,8'd0,8'd0,8'd255,8'd0, 8'd77,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2'd2,8'd1,8'd0,8'd255,8'd0, 8'd76,0,0,0,0,0,0));

        // reset state
        #23;
        chk("rst.q", {24'd0, q}, 32'd0);
        chk("rst.dir", {31'd0, dir}, 32'd1);
        chk("rst.evt", {31'd0, evt}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.min_tick", {31'd0, min_tick}, 32'd0);
        chk("rst.cfg_err", {31'd0, cfg_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(i, tbl[i]);
        end

        // asynchronous reset in the middle of an event pulse
        drive(mk(0,1,0,1,2'd0,8'd3,8'd10,8'd20,8'd19, 8'd0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        en = 1'b1; load = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.q", {24'd0, q}, 32'd10);
        chk("mid.evt", {31'd0, evt}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.q", {24'd0, q}, 32'd0);
        chk("arst.dir", {31'd0, dir}, 32'd1);
        chk("arst.evt", {31'd0, evt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(0,0,1,1,2'd0,8'd5,8'd0,8'd255,8'd0, 8'd0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk("post_rst.q", {24'd0, q}, 32'd5);
        chk("post_rst.evt", {31'd0, evt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_univ_counter.md
# prog_univ_counter

Parametrised bounded up/down counter with programmable lower and upper limits, programmable step, and four boundary modes: wrap, saturate, bounce (ping-pong) and one-shot. It is the general-purpose successor to the plain universal counter. It serves timers, PWM carriers, address sequencers and scan generators that need limits other than 0 and 2^W-1. Registered boundary events and a sticky done flag let control FSMs sequence on it without extra compare logic.

## Interface
- `W`, 8: counter, limit, step and load width in bits (W ≥ 2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset. This is the only clock and reset.
- `clr`  in  1  synchronous clear to `lo`.
- `load`  in  1  synchronous load of `d`.
- `en`  in  1  count enable.
- `up`  in  1  count direction: 1 = up, 0 = down.
- `mode`  in  2  boundary mode: 00 wrap, 01 saturate, 10 bounce, 11 one-shot.
- `step`  in  W  increment per enabled cycle, unsigned.
- `lo`  in  W  lower limit, unsigned.
- `hi`  in  W  upper limit, unsigned.
- `d`  in  W  load value.
- `q`  out  W  count, registered.
- `dir`  out  1  effective direction, registered.
- `evt`  out  1  boundary-event pulse, registered.
- `done`  out  1  one-shot terminated, registered, sticky.
- `max_tick`  out  1  combinational: `q == hi`.
- `min_tick`  out  1  combinational: `q == lo`.
- `cfg_err`  out  1  combinational: `lo > hi`.

## Operation
- Priority per edge is fixed:
  - `clr`: `q←lo`, `dir←up`, `done←0`, `evt←0`.
  - else `load`: `q←d` (any value, in or out of range), `dir←up`, `done←0`, `evt←0`.
  - else count step, taken only if `en=1`, `cfg_err=0`, `step≠0`, and not (`mode=11` and `done=1`).
  - else hold: `q`, `dir`, `done` keep their values; `evt←0`.
- Effective direction:
  - Modes 00, 01, 11: `dir←up` on every count step.
  - Mode 10: `up` is ignored during counting. `dir` is the internal ping-pong state. It is seeded from `up` by `clr` or `load` only.
- Arithmetic is done in W+1 bits, so a carry or borrow past 2^W-1 or 0 is never lost.
  - Up event: `{0,q}+step > {0,hi}`.
  - Down event: `{0,q} < {0,lo}+step`.
  - No event: `q ← q±step`.
- On a boundary event:
  - Wrap (00): up `q←lo`; down `q←hi`. The excess is discarded, not carried modulo.
  - Saturate (01): up `q←hi`; down `q←lo`. This repeats every enabled cycle while at the bound.
  - Bounce (10): up `q←hi`, `dir←0`; down `q←lo`, `dir←1`.
  - One-shot (11): up `q←hi`; down `q←lo`; `done←1`. Counting then stops until `clr` or `load`.
- `evt←1` in exactly the cycle a boundary event is taken, otherwise 0. `evt` is high in the same cycle `q` shows the boundary value.
- `done←0` whenever `mode≠11`.
- Changes to `mode`, `lo`, `hi` or `step` take effect at the next edge. Entering bounce keeps the current `dir`.
- With `cfg_err=1`, counting is suppressed, `evt` stays 0, and `clr`/`load` still work.

## Timing
- Reset (`rst_n=0`, asynchronous): `q=0`, `dir=1`, `evt=0`, `done=0`. `max_tick`, `min_tick` and `cfg_err` follow from `q=0` and the current limits.
- Reset release is synchronous in effect: the first edge with `rst_n=1` applies normal priority.
- Latency:
  - Inputs to `q`, `dir`, `evt`, `done`: 1 clock.
  - `q`, `lo`, `hi` to `max_tick`, `min_tick`, `cfg_err`: combinational, 0 clocks.
- Reset asserted mid-count or mid-pulse clears all registers immediately. `evt` never extends past reset.
- Throughput: one step per enabled clock, with no bubbles at boundaries.

## Test plan
- Wrap up, W=8, `lo=10`, `hi=20`, `step=3`, load 18, `en=1`: `q` = 18, 10, 13, 16, 19, 10. `evt=1` exactly when `q=10` after a wrap.
- Saturate down, `lo=5`, `step=4`, load 12: `q` = 12, 8, 5, 5. `evt` = 0, 0, 1, 1. `min_tick=1` from the first 5.
- Bounce, `lo=0`, `hi=7`, `step=2`, `clr` with `up=1`, then `up=0` held: `q` = 0, 2, 4, 6, 7, 5, 3, 1, 0, 2. `dir` falls at 7 and rises at 0.
- One-shot, `lo=0`, `hi=255`, `step=100`, `up=1`: `q` = 0, 100, 200, 255; `done=1` and `q` holds at 255. Load `d=0` clears `done`, and counting resumes.
- Carry boundary, wrap mode, `lo=3`, `hi=255`, `step=10`, load 250: next `q=3` with `evt=1`, not 4.
- Priority and reset:
  - `clr=1` and `load=1` together: `q=lo`.
  - `lo=9`, `hi=3`, `en=1`: `cfg_err=1` and `q` holds.
  - `rst_n` pulsed low between edges mid-count: `q=0`, `dir=1` immediately.
